cv32e40p_ft_replica_manager: RTL and testbench



---
 rtl/cv32e40p_ft_replica_manager_pkg.sv | 24 ++
 rtl/cv32e40p_ft_replica_manager_err_counter.sv | 61 ++++++
 rtl/cv32e40p_ft_replica_manager.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_cv32e40p_ft_replica_manager.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_ft_replica_manager_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared types and default constants for the fault-tolerant replica manager.
//   ft_mgr_state_e : swap state machine encoding (IDLE, WARM, COMMIT, DEGRADED)
//   FT_*_DEFAULT   : default parameter values of the manager
//   FT_N_SLOT      : number of voter slots (fixed triple-modular voting)
// -----------------------------------------------------------------------------
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WARM     = 2'd1,
        COMMIT   = 2'd2,
        DEGRADED = 2'd3
    } ft_mgr_state_e;

    localparam int FT_N_SLOT               = 3;
    localparam int FT_N_REP_DEFAULT        = 4;
    localparam int FT_CNT_W_DEFAULT        = 8;
    localparam int FT_THRESH_DEFAULT       = 200;
    localparam int FT_WARM_CYC_DEFAULT     = 2;
    localparam int FT_DECAY_PERIOD_DEFAULT = 1024;

endpackage

// File: rtl/cv32e40p_ft_replica_manager_err_counter.sv
// -----------------------------------------------------------------------------
// cv32e40p_ft_err_counter
// Saturating per-replica error counter with clear and optional decrement.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : zero the counter (highest priority)
//   inc_i    : add one, saturating at all-ones
//   dec_i    : subtract one if non-zero (tie low when decay is not built)
//   cnt_o    : current count
// -----------------------------------------------------------------------------
module cv32e40p_ft_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear beats increment beats decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_ZERO;
        end else if (inc_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (dec_i) begin
            if (cnt_q != CNT_ZERO) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_replica_manager.sv
// -----------------------------------------------------------------------------
// cv32e40p_ft_replica_manager
// Tracks voter disagreements per replica, declares replicas permanently faulty
// at THRESH errors and hot-swaps a spare into the affected voter slot after a
// WARM_CYC-cycle warm-up. With no spare left the mapping freezes (degraded).
//
// Optional feature macro: FT_ERR_DECAY_EN -- every DECAY_PERIOD consecutive
// error-free valid cycles, each non-zero active counter decrements by one.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   valid_i        : a voted operation completed this cycle
//   err_slot_i     : per-slot disagreement flags
//   clear_i        : zero all error counters
//   sel_o          : replica index feeding each of the three voter slots
//   active_mask_o  : replicas mapped to a slot
//   clock_en_o     : per-replica clock enable (active or warming spare)
//   faulty_o       : sticky permanent-fault flags
//   perf_trig_o    : one-cycle pulse when a replica is declared faulty
//   swap_busy_o    : swap in progress (WARM or COMMIT)
//   degraded_o     : a fault was found with no spare left
//   fatal_o        : sticky, all three slots disagreed at once
// -----------------------------------------------------------------------------
import cv32e40p_pkg::*;

module cv32e40p_ft_replica_manager #(
    parameter int N_REP        = FT_N_REP_DEFAULT,
    parameter int CNT_W        = FT_CNT_W_DEFAULT,
    parameter int THRESH       = FT_THRESH_DEFAULT,
    parameter int WARM_CYC     = FT_WARM_CYC_DEFAULT,
    parameter int DECAY_PERIOD = FT_DECAY_PERIOD_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [2:0]                   err_slot_i,
    input  logic                         clear_i,
    output logic [3*$clog2(N_REP)-1:0]   sel_o,
    output logic [N_REP-1:0]             active_mask_o,
    output logic [N_REP-1:0]             clock_en_o,
    output logic [N_REP-1:0]             faulty_o,
    output logic [N_REP-1:0]             perf_trig_o,
    output logic                         swap_busy_o,
    output logic                         degraded_o,
    output logic                         fatal_o
);

    localparam int SEL_W = $clog2(N_REP);
    localparam int NS    = FT_N_SLOT;

    // Identity mapping: slot k is fed by replica k.
    function automatic logic [NS*SEL_W-1:0] sel_reset();
        logic [NS*SEL_W-1:0] v;
        v = '0;
        for (int k = 0; k < NS; k++) begin
            v[k*SEL_W +: SEL_W] = SEL_W'(k);
        end
        return v;
    endfunction

    localparam logic [NS*SEL_W-1:0] SEL_RST    = sel_reset();
    localparam logic [N_REP-1:0]    ACTIVE_RST = N_REP'(3'b111);

    ft_mgr_state_e         state_d, state_q;
    logic [2:0]            warm_d, warm_q;
    logic [1:0]            fslot_d, fslot_q;
    logic [SEL_W-1:0]      spare_d, spare_q;
    logic [NS*SEL_W-1:0]   sel_d, sel_q;
    logic [N_REP-1:0]      active_d, active_q;
    logic [N_REP-1:0]      clk_en_d, clk_en_q;
    logic [N_REP-1:0]      faulty_d, faulty_q;
    logic [N_REP-1:0]      trig_d, trig_q;
    logic                  busy_d, busy_q;
    logic                  deg_d, deg_q;
    logic                  fatal_d, fatal_q;

    logic [N_REP-1:0]      inc_s;
    logic [CNT_W-1:0]      cnt_s [N_REP];
    logic                  decay_s;
    logic                  commit_s;
    logic                  hit_s;
    logic [1:0]            hit_slot_s;
    logic [SEL_W-1:0]      hit_rep_s;
    logic [SEL_W-1:0]      rep_s;
    logic                  spare_found_s;
    logic [SEL_W-1:0]      spare_s;
    logic [SEL_W-1:0]      frep_s;

    // Increment the replica mapped to each flagged slot; an all-slot
    // disagreement has no majority and is not charged to anyone.
    always_comb begin
        inc_s = '0;
        if (valid_i && (err_slot_i != 3'b111)) begin
            for (int k = 0; k < NS; k++) begin
                if (err_slot_i[k]) begin
                    inc_s[sel_q[k*SEL_W +: SEL_W]] = 1'b1;
                end else begin
                    inc_s = inc_s;
                end
            end
        end else begin
            inc_s = '0;
        end
    end

`ifdef FT_ERR_DECAY_EN
    localparam int PER_W = $clog2(DECAY_PERIOD + 1);

    logic [PER_W-1:0] per_d, per_q;

    // Count consecutive clean valid cycles; any error restarts the period.
    always_comb begin
        per_d   = per_q;
        decay_s = 1'b0;
        if (valid_i) begin
            if (err_slot_i == 3'b000) begin
                if (per_q == PER_W'(DECAY_PERIOD - 1)) begin
                    per_d   = '0;
                    decay_s = 1'b1;
                end else begin
                    per_d = per_q + PER_W'(1);
                end
            end else begin
                per_d = '0;
            end
        end else begin
            per_d = per_q;
        end
    end

    // Decay period register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end
`else
    assign decay_s = 1'b0;
`endif

    for (genvar r = 0; r < N_REP; r++) begin : g_cnt
        cv32e40p_ft_err_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (clear_i | (commit_s & (spare_q == SEL_W'(r)))),
            .inc_i (inc_s[r]),
            .dec_i (decay_s & active_q[r]),
            .cnt_o (cnt_s[r])
        );
    end

    // Lowest slot whose non-faulty replica has reached the threshold, and
    // lowest-index replica that is neither mapped nor faulty.
    always_comb begin
        hit_s         = 1'b0;
        hit_slot_s    = 2'd0;
        hit_rep_s     = '0;
        rep_s         = '0;
        spare_found_s = 1'b0;
        spare_s       = '0;
        for (int k = 0; k < NS; k++) begin
            rep_s = sel_q[k*SEL_W +: SEL_W];
            if (!hit_s && !faulty_q[rep_s] && (cnt_s[rep_s] >= CNT_W'(THRESH))) begin
                hit_s      = 1'b1;
                hit_slot_s = 2'(k);
                hit_rep_s  = rep_s;
            end else begin
                hit_s = hit_s;
            end
        end
        for (int r = N_REP - 1; r >= 0; r--) begin
            if (!active_q[r] && !faulty_q[r]) begin
                spare_found_s = 1'b1;
                spare_s       = SEL_W'(r);
            end else begin
                spare_found_s = spare_found_s;
            end
        end
    end

    assign frep_s = sel_q[int'(fslot_q)*SEL_W +: SEL_W];

    // Swap state machine next-state and output logic.
    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        fslot_d  = fslot_q;
        spare_d  = spare_q;
        sel_d    = sel_q;
        active_d = active_q;
        faulty_d = faulty_q;
        trig_d   = '0;
        busy_d   = busy_q;
        deg_d    = deg_q;
        fatal_d  = fatal_q | (valid_i & (err_slot_i == 3'b111));
        commit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    faulty_d[hit_rep_s] = 1'b1;
                    trig_d[hit_rep_s]   = 1'b1;
                    fslot_d             = hit_slot_s;
                    if (spare_found_s) begin
                        state_d = WARM;
                        spare_d = spare_s;
                        warm_d  = 3'd0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DEGRADED;
                        deg_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WARM: begin
                if (warm_q == 3'(WARM_CYC - 1)) begin
                    state_d = COMMIT;
                end else begin
                    warm_d = warm_q + 3'd1;
                end
            end
            COMMIT: begin
                commit_s                              = 1'b1;
                sel_d[int'(fslot_q)*SEL_W +: SEL_W]   = spare_q;
                active_d[frep_s]                      = 1'b0;
                active_d[spare_q]                     = 1'b1;
                busy_d                                = 1'b0;
                state_d                               = IDLE;
            end
            DEGRADED: begin
                state_d = DEGRADED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The spare is clocked from the start of warm-up onwards.
        if ((state_d == WARM) || (state_d == COMMIT)) begin
            clk_en_d = active_d | (N_REP'(1) << spare_d);
        end else begin
            clk_en_d = active_d;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            warm_q   <= 3'd0;
            fslot_q  <= 2'd0;
            spare_q  <= '0;
            sel_q    <= SEL_RST;
            active_q <= ACTIVE_RST;
            clk_en_q <= ACTIVE_RST;
            faulty_q <= '0;
            trig_q   <= '0;
            busy_q   <= 1'b0;
            deg_q    <= 1'b0;
            fatal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            fslot_q  <= fslot_d;
            spare_q  <= spare_d;
            sel_q    <= sel_d;
            active_q <= active_d;
            clk_en_q <= clk_en_d;
            faulty_q <= faulty_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            deg_q    <= deg_d;
            fatal_q  <= fatal_d;
        end
    end

    assign sel_o         = sel_q;
    assign active_mask_o = active_q;
    assign clock_en_o    = clk_en_q;
    assign faulty_o      = faulty_q;
    assign perf_trig_o   = trig_q;
    assign swap_busy_o   = busy_q;
    assign degraded_o    = deg_q;
    assign fatal_o       = fatal_q;

endmodule

// File: tb/tb_cv32e40p_ft_replica_manager.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_ft_replica_manager
// Directed scenarios plus randomized traffic, checked cycle by cycle against a
// behavioural model of the replica manager (N_REP=4, THRESH=4, WARM_CYC=2,
// DECAY_PERIOD=8). Decay expectations follow FT_ERR_DECAY_EN.
// -----------------------------------------------------------------------------
module tb_cv32e40p_ft_replica_manager;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int TH = 4;
    localparam int WC = 2;
    localparam int DP = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic [2:0]      err_slot_i;
    logic            clear_i;
    logic [3*SW-1:0] sel_o;
    logic [N-1:0]    active_mask_o;
    logic [N-1:0]    clock_en_o;
    logic [N-1:0]    faulty_o;
    logic [N-1:0]    perf_trig_o;
    logic            swap_busy_o;
    logic            degraded_o;
    logic            fatal_o;

    cv32e40p_ft_replica_manager #(
        .N_REP        (N),
        .CNT_W        (CW),
        .THRESH       (TH),
        .WARM_CYC     (WC),
        .DECAY_PERIOD (DP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .err_slot_i    (err_slot_i),
        .clear_i       (clear_i),
        .sel_o         (sel_o),
        .active_mask_o (active_mask_o),
        .clock_en_o    (clock_en_o),
        .faulty_o      (faulty_o),
        .perf_trig_o   (perf_trig_o),
        .swap_busy_o   (swap_busy_o),
        .degraded_o    (degraded_o),
        .fatal_o       (fatal_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: error counts per replica, slot->replica map, and a
    // countdown of remaining swap-busy cycles.
    int       m_cnt [N];
    int       m_map [3];
    bit [N-1:0] m_faulty, m_active, m_trig;
    int       m_busy, m_spare, m_fslot, m_run;
    bit       m_deg, m_fatal;

    task automatic model_reset();
        for (int r = 0; r < N; r++) m_cnt[r] = 0;
        for (int k = 0; k < 3; k++) m_map[k] = k;
        m_faulty = '0; m_active = 4'b0111; m_trig = '0;
        m_busy = 0; m_spare = 0; m_fslot = 0; m_run = 0;
        m_deg = 1'b0; m_fatal = 1'b0;
    endtask

    task automatic model_step(bit v, bit [2:0] e, bit c);
        int old_cnt [N];
        bit [N-1:0] old_active;
        int hit;
        old_cnt    = m_cnt;
        old_active = m_active;
        hit        = -1;
        if (c) begin
            for (int r = 0; r < N; r++) m_cnt[r] = 0;
        end else if (v && e != 3'b111) begin
            for (int k = 0; k < 3; k++)
                if (e[k] && m_cnt[m_map[k]] < (2**CW - 1)) m_cnt[m_map[k]]++;
        end
`ifdef FT_ERR_DECAY_EN
        if (v) begin
            if (e == 3'b000) begin
                m_run++;
                if (m_run == DP) begin
                    m_run = 0;
                    if (!c)
                        for (int r = 0; r < N; r++)
                            if (old_active[r] && m_cnt[r] > 0) m_cnt[r]--;
                end
            end else begin
                m_run = 0;
            end
        end
`endif
        m_trig = '0;
        if (v && e == 3'b111) m_fatal = 1'b1;
        if (m_busy == 0 && !m_deg) begin
            for (int k = 2; k >= 0; k--)
                if (!m_faulty[m_map[k]] && old_cnt[m_map[k]] >= TH) hit = k;
            if (hit >= 0) begin
                m_faulty[m_map[hit]] = 1'b1;
                m_trig[m_map[hit]]   = 1'b1;
                m_fslot = hit;
                m_spare = -1;
                for (int r = N - 1; r >= 0; r--)
                    if (!m_active[r] && !m_faulty[r]) m_spare = r;
                if (m_spare >= 0) m_busy = WC + 1;
                else m_deg = 1'b1;
            end
        end else if (m_busy > 0) begin
            if (m_busy == 1) begin
                m_cnt[m_spare] = 0;
                m_active[m_map[m_fslot]] = 1'b0;
                m_active[m_spare] = 1'b1;
                m_map[m_fslot] = m_spare;
            end
            m_busy--;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [3*SW-1:0] esel;
        logic [N-1:0]    eclk;
        esel = '0;
        for (int k = 0; k < 3; k++) esel[k*SW +: SW] = SW'(m_map[k]);
        eclk = m_active;
        if (m_busy > 0) eclk[m_spare] = 1'b1;
        chk({tag, ".sel"},    32'(sel_o),         32'(esel));
        chk({tag, ".active"}, 32'(active_mask_o), 32'(m_active));
        chk({tag, ".clken"},  32'(clock_en_o),    32'(eclk));
        chk({tag, ".faulty"}, 32'(faulty_o),      32'(m_faulty));
        chk({tag, ".trig"},   32'(perf_trig_o),   32'(m_trig));
        chk({tag, ".busy"},   32'(swap_busy_o),   32'(m_busy > 0));
        chk({tag, ".deg"},    32'(degraded_o),    32'(m_deg));
        chk({tag, ".fatal"},  32'(fatal_o),       32'(m_fatal));
    endtask

    task automatic cyc(string tag, bit v, bit [2:0] e, bit c);
        valid_i = v; err_slot_i = e; clear_i = c;
        @(posedge clk);
        model_step(v, e, c);
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, ".sel"},    32'(sel_o),         32'h24);
        chk({tag, ".active"}, 32'(active_mask_o), 32'h7);
        chk({tag, ".clken"},  32'(clock_en_o),    32'h7);
        chk({tag, ".faulty"}, 32'(faulty_o),      32'h0);
        chk({tag, ".trig"},   32'(perf_trig_o),   32'h0);
        chk({tag, ".flags"},  32'({swap_busy_o, degraded_o, fatal_o}), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = 1'b0; err_slot_i = 3'b000; clear_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_reset_values("reset");
        rst = 1'b0;
    endtask

    initial begin
        int busy_len;
        logic [N-1:0] trig_seen;
        bit [2:0] e;
        rst = 1'b1; valid_i = 1'b0; err_slot_i = 3'b000; clear_i = 1'b0;
        #2;

        // Single-slot fault swaps replica 1 out for spare 3.
        do_reset();
        for (int i = 0; i < 4; i++) cyc("s34.err", 1'b1, 3'b010, 1'b0);
        chk("s34.no_trig_yet", 32'(perf_trig_o), 32'h0);
        busy_len = 0;
        cyc("s34.detect", 1'b0, 3'b000, 1'b0);
        chk("s34.trig", 32'(perf_trig_o), 32'h2);
        for (int i = 0; i < 6; i++) begin
            if (swap_busy_o) busy_len++;
            cyc("s34.swap", 1'b0, 3'b000, 1'b0);
        end
        chk("s34.busy_len", 32'(busy_len), 32'd3);
        chk("s34.sel1", 32'(sel_o[SW +: SW]), 32'd3);
        chk("s34.active", 32'(active_mask_o), 32'hd);

        // Second fault with no spare left: degrade, mapping frozen.
        for (int i = 0; i < 4; i++) cyc("s35.err", 1'b1, 3'b001, 1'b0);
        for (int i = 0; i < 3; i++) cyc("s35.idle", 1'b0, 3'b000, 1'b0);
        chk("s35.faulty", 32'(faulty_o), 32'h3);
        chk("s35.deg", 32'(degraded_o), 32'h1);
        chk("s35.sel", 32'(sel_o), 32'h2c);

        // All-slot disagreement sets fatal and charges no counter.
        do_reset();
        for (int i = 0; i < 3; i++) cyc("s36.err", 1'b1, 3'b010, 1'b0);
        cyc("s36.fatal", 1'b1, 3'b111, 1'b0);
        cyc("s36.fatal2", 1'b1, 3'b111, 1'b0);
        cyc("s36.idle", 1'b0, 3'b000, 1'b0);
        chk("s36.fatal_o", 32'(fatal_o), 32'h1);
        chk("s36.no_trig", 32'(perf_trig_o), 32'h0);
        cyc("s36.err4", 1'b1, 3'b010, 1'b0);
        cyc("s36.detect", 1'b0, 3'b000, 1'b0);
        chk("s36.trig", 32'(perf_trig_o), 32'h2);

        // Clear wins over a same-cycle error.
        do_reset();
        for (int i = 0; i < 3; i++) cyc("clr.err", 1'b1, 3'b100, 1'b0);
        cyc("clr.clr", 1'b1, 3'b100, 1'b1);
        for (int i = 0; i < 3; i++) cyc("clr.err2", 1'b1, 3'b100, 1'b0);
        cyc("clr.idle", 1'b0, 3'b000, 1'b0);
        chk("clr.no_trig", 32'(perf_trig_o), 32'h0);

        // Two slots cross together: slot 0 swapped first, slot 2 degrades.
        do_reset();
        for (int i = 0; i < 4; i++) cyc("s37.err", 1'b1, 3'b101, 1'b0);
        cyc("s37.detect0", 1'b0, 3'b000, 1'b0);
        chk("s37.trig0", 32'(perf_trig_o), 32'h1);
        for (int i = 0; i < 3; i++) cyc("s37.swap", 1'b0, 3'b000, 1'b0);
        chk("s37.sel0", 32'(sel_o[0 +: SW]), 32'd3);
        cyc("s37.detect2", 1'b0, 3'b000, 1'b0);
        chk("s37.trig2", 32'(perf_trig_o), 32'h4);
        chk("s37.deg", 32'(degraded_o), 32'h1);
        chk("s37.faulty", 32'(faulty_o), 32'h5);

        // Decay: 3 errors, 8 clean valid cycles, then one more error.
        do_reset();
        for (int i = 0; i < 3; i++) cyc("s38.err", 1'b1, 3'b001, 1'b0);
        for (int i = 0; i < DP; i++) cyc("s38.clean", 1'b1, 3'b000, 1'b0);
        cyc("s38.err4", 1'b1, 3'b001, 1'b0);
        trig_seen = '0;
        for (int i = 0; i < 2; i++) begin
            cyc("s38.idle", 1'b0, 3'b000, 1'b0);
            trig_seen |= perf_trig_o;
        end
`ifdef FT_ERR_DECAY_EN
        chk("s38.trig_decay", 32'(trig_seen), 32'h0);
`else
        chk("s38.trig_nodecay", 32'(trig_seen), 32'h1);
`endif

        // Reset in the middle of warm-up abandons the swap.
        do_reset();
        for (int i = 0; i < 4; i++) cyc("s39.err", 1'b1, 3'b100, 1'b0);
        cyc("s39.detect", 1'b0, 3'b000, 1'b0);
        chk("s39.busy", 32'(swap_busy_o), 32'h1);
        #3 rst = 1'b1;
        #1 check_reset_values("s39.async");
        model_reset();
        @(posedge clk); #1;
        check_reset_values("s39.next");
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int i = 0; i < 200; i++) begin
                case ($urandom_range(0, 15))
                    0, 1:    e = 3'b001;
                    2:       e = 3'b010;
                    3:       e = 3'b100;
                    4:       e = 3'(1 << $urandom_range(0, 2)) | 3'b001;
                    5:       e = (round > 3) ? 3'b111 : 3'b000;
                    default: e = 3'b000;
                endcase
                cyc("rand", 1'($urandom_range(0, 3) != 0), e,
                    1'($urandom_range(0, 99) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
